// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline stall/flush sequencer (optional stall counter: HAZARD_STALL_CNT_EN)
module hazard_controller #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       id_valid,
    input  logic [4:0] id_rsA,
    input  logic [4:0] id_rsB,
    input  logic       id_use_in_id,
    input  logic       id_redirect,
    input  logic       exe_valid,
    input  logic [4:0] exe_rd,
    input  logic       exe_wr_en,
    input  logic       exe_is_load,
    input  logic       exe_is_div,
    output logic       if_stall,
    output logic       id_stall,
    output logic       exe_stall,
    output logic       id_flush,
    output logic       mem_flush,
    output logic       if_flush,
    output logic       div_start,
    output logic       div_busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] DIV_WAIT = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    localparam logic [7:0] CNT_INIT = 8'(DIV_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       ld_haz;

    // Only loads that feed an ID-stage consumer need a bubble; EXE-stage users are forwarded.
    assign ld_haz = exe_valid & exe_is_load & exe_wr_en & (exe_rd != 5'd0) &
                    id_valid & id_use_in_id &
                    ((id_rsA == exe_rd) | (id_rsB == exe_rd));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        exe_stall = 1'b0;
        id_flush  = 1'b0;
        mem_flush = 1'b0;
        div_start = 1'b0;
        div_busy  = 1'b0;
        case (state)
            RUN: begin
                if (exe_valid && exe_is_div) begin
                    div_start = 1'b1;
                    if_stall  = 1'b1;
                    id_stall  = 1'b1;
                    exe_stall = 1'b1;
                    mem_flush = 1'b1;
                    state_nxt = DIV_WAIT;
                    cnt_nxt   = CNT_INIT;
                end else if (ld_haz) begin
                    if_stall = 1'b1;
                    id_stall = 1'b1;
                    id_flush = 1'b1;
                end
            end
            DIV_WAIT: begin
                if_stall  = 1'b1;
                id_stall  = 1'b1;
                exe_stall = 1'b1;
                mem_flush = 1'b1;
                div_busy  = 1'b1;
                cnt_nxt   = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    state_nxt = DIV_DONE;
                end
            end
            DIV_DONE: begin
                // The div is still visible in EXE here; the pipeline advances instead of restarting it.
                div_busy  = 1'b1;
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = 8'd0;
            end
        endcase
        // A stalled ID cannot redirect; the branch re-presents once ID releases.
        if_flush = id_redirect & id_valid & ~id_stall;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= RUN;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cnt <= 32'd0;
        end else if (if_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    // No stall counter in this build.
`endif

endmodule
